// File: rtl/defines_pkg.sv
// Shared types for the SPU dual-issue controller: opcodes, issue FSM states, scoreboard entries.
package defines_pkg;

  localparam int unsigned RegAw = 7;
  localparam int unsigned LatW  = 3;

  typedef enum logic [3:0] {
    OpNop    = 4'd0,
    OpAdd    = 4'd1,
    OpSub    = 4'd2,
    OpLoad   = 4'd3,
    OpStore  = 4'd4,
    OpShuf   = 4'd5,
    OpBranch = 4'd6
  } Opcodes;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    PAIR  = 2'd1,
    SLOT1 = 2'd2
  } issue_state_e;

  typedef struct packed {
    logic             valid;
    logic             wr;
    logic [RegAw-1:0] rt;
    logic [LatW-1:0]  lat;
    logic [LatW-1:0]  stage;
  } SbEntry;

  typedef struct packed {
    logic             pipe;
    logic [LatW-1:0]  lat;
    logic             wr;
    logic [RegAw-1:0] rt;
    logic [RegAw-1:0] ra;
    logic [RegAw-1:0] rb;
    logic [RegAw-1:0] rc;
    logic             use_a;
    logic             use_b;
    logic             use_c;
    Opcodes           opcode;
  } slot_t;

  function automatic logic src_match(slot_t s, logic [RegAw-1:0] r);
    return (s.use_a && (s.ra == r)) || (s.use_b && (s.rb == r)) || (s.use_c && (s.rc == r));
  endfunction

  function automatic logic [31:0] sat_add(logic [31:0] v, logic [1:0] n);
    logic [32:0] s;
    s = {1'b0, v} + {31'b0, n};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

endpackage

// File: rtl/spu_issue_ctrl_if.sv
// Decode-to-issue bundle: instruction pair offer/accept, flush, and per-pipe issue outputs.
interface spu_issue_ctrl_if #(
    parameter int unsigned REG_ADDR_WD = 7
);
    import defines_pkg::*;

    logic                   pair_valid;
    logic                   pair_ready;
    logic                   flush;

    logic                   s0_pipe,  s1_pipe;
    logic [2:0]             s0_lat,   s1_lat;
    logic                   s0_wr,    s1_wr;
    logic [REG_ADDR_WD-1:0] s0_rt,    s1_rt;
    logic [REG_ADDR_WD-1:0] s0_ra,    s1_ra;
    logic [REG_ADDR_WD-1:0] s0_rb,    s1_rb;
    logic [REG_ADDR_WD-1:0] s0_rc,    s1_rc;
    logic                   s0_use_a, s1_use_a;
    logic                   s0_use_b, s1_use_b;
    logic                   s0_use_c, s1_use_c;
    Opcodes                 s0_opcode, s1_opcode;

    logic                   iss_ep_valid, iss_op_valid;
    Opcodes                 iss_ep_opcode, iss_op_opcode;
    logic [REG_ADDR_WD-1:0] iss_ep_rt, iss_ep_ra, iss_ep_rb, iss_ep_rc;
    logic [REG_ADDR_WD-1:0] iss_op_rt, iss_op_ra, iss_op_rb, iss_op_rc;

    modport master (
        output pair_valid, flush,
        output s0_pipe, s0_lat, s0_wr, s0_rt, s0_ra, s0_rb, s0_rc,
        output s0_use_a, s0_use_b, s0_use_c, s0_opcode,
        output s1_pipe, s1_lat, s1_wr, s1_rt, s1_ra, s1_rb, s1_rc,
        output s1_use_a, s1_use_b, s1_use_c, s1_opcode,
        input  pair_ready,
        input  iss_ep_valid, iss_ep_opcode, iss_ep_rt, iss_ep_ra, iss_ep_rb, iss_ep_rc,
        input  iss_op_valid, iss_op_opcode, iss_op_rt, iss_op_ra, iss_op_rb, iss_op_rc
    );

    modport slave (
        input  pair_valid, flush,
        input  s0_pipe, s0_lat, s0_wr, s0_rt, s0_ra, s0_rb, s0_rc,
        input  s0_use_a, s0_use_b, s0_use_c, s0_opcode,
        input  s1_pipe, s1_lat, s1_wr, s1_rt, s1_ra, s1_rb, s1_rc,
        input  s1_use_a, s1_use_b, s1_use_c, s1_opcode,
        output pair_ready,
        output iss_ep_valid, iss_ep_opcode, iss_ep_rt, iss_ep_ra, iss_ep_rb, iss_ep_rc,
        output iss_op_valid, iss_op_opcode, iss_op_rt, iss_op_ra, iss_op_rb, iss_op_rc
    );

endinterface

// File: rtl/spu_scoreboard.sv
// Pending-write tracker for both pipes: one shift chain per pipe, slot k holds stage k+2.
module spu_scoreboard
    import defines_pkg::*;
#(
    parameter int unsigned REG_ADDR_WD = 7,
    parameter int unsigned MAX_LAT     = 7,
    parameter int unsigned NUM_Q       = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             i_ins_valid,
    input  logic [REG_ADDR_WD-1:0] i_ins_rt  [2],
    input  logic [LatW-1:0]        i_ins_lat [2],
    input  logic [REG_ADDR_WD-1:0] i_q_addr  [NUM_Q],
    output logic [NUM_Q-1:0]       o_q_busy
);
    localparam int unsigned Depth = MAX_LAT - 1;

    SbEntry r_ent   [2][Depth];
    SbEntry w_ent_d [2][Depth];

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            w_ent_d[p][0] = '{valid: i_ins_valid[p], wr: 1'b1, rt: i_ins_rt[p],
                              lat: i_ins_lat[p], stage: LatW'(2)};
            for (int k = 1; k < Depth; k++) begin
                w_ent_d[p][k]       = r_ent[p][k-1];
                w_ent_d[p][k].stage = r_ent[p][k-1].stage + LatW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int p = 0; p < 2; p++) begin
                for (int k = 0; k < Depth; k++) begin
                    r_ent[p][k] <= '0;
                end
            end
        end else begin
            r_ent <= w_ent_d;
        end
    end

    // A write is still pending until its entry reaches its result-ready stage.
    always_comb begin
        o_q_busy = '0;
        for (int q = 0; q < NUM_Q; q++) begin
            for (int p = 0; p < 2; p++) begin
                for (int k = 0; k < Depth; k++) begin
                    if (r_ent[p][k].valid && r_ent[p][k].wr && (r_ent[p][k].rt == i_q_addr[q])
                        && (r_ent[p][k].stage < r_ent[p][k].lat)) begin
                        o_q_busy[q] = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/spu_issue_ctrl.sv
// In-order dual-issue controller for the SPU even/odd pipes with RAW scoreboard.
// Optional SPU_ISSUE_STATS_EN adds saturating issue/stall counters.
module spu_issue_ctrl
    import defines_pkg::*;
#(
    parameter int unsigned REG_ADDR_WD = 7,
    parameter int unsigned MAX_LAT     = 7
) (
    input  logic            clk,
    input  logic            rst,
`ifdef SPU_ISSUE_STATS_EN
    output logic [31:0]     stat_issue_cnt,
    output logic [31:0]     stat_raw_stall_cnt,
    output logic [31:0]     stat_struct_stall_cnt,
`endif
    spu_issue_ctrl_if.slave issue_bus
);
    issue_state_e r_state, w_state_d;
    slot_t        r_s0, r_s1, w_s0_d, w_s1_d, w_in0, w_in1;

    logic [REG_ADDR_WD-1:0] w_q_addr [6];
    logic [5:0]             w_busy;
    logic [1:0]             w_ins_valid;
    logic [REG_ADDR_WD-1:0] w_ins_rt  [2];
    logic [LatW-1:0]        w_ins_lat [2];
    logic w_s0_haz, w_s1_haz, w_dep, w_iss0, w_iss1, w_ready, w_accept;

    assign w_in0 = '{pipe: issue_bus.s0_pipe, lat: issue_bus.s0_lat, wr: issue_bus.s0_wr,
                     rt: issue_bus.s0_rt, ra: issue_bus.s0_ra, rb: issue_bus.s0_rb,
                     rc: issue_bus.s0_rc, use_a: issue_bus.s0_use_a, use_b: issue_bus.s0_use_b,
                     use_c: issue_bus.s0_use_c, opcode: issue_bus.s0_opcode};
    assign w_in1 = '{pipe: issue_bus.s1_pipe, lat: issue_bus.s1_lat, wr: issue_bus.s1_wr,
                     rt: issue_bus.s1_rt, ra: issue_bus.s1_ra, rb: issue_bus.s1_rb,
                     rc: issue_bus.s1_rc, use_a: issue_bus.s1_use_a, use_b: issue_bus.s1_use_b,
                     use_c: issue_bus.s1_use_c, opcode: issue_bus.s1_opcode};

    assign w_q_addr = '{r_s0.ra, r_s0.rb, r_s0.rc, r_s1.ra, r_s1.rb, r_s1.rc};

    spu_scoreboard #(
        .REG_ADDR_WD (REG_ADDR_WD),
        .MAX_LAT     (MAX_LAT),
        .NUM_Q       (6)
    ) u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .i_ins_valid (w_ins_valid),
        .i_ins_rt    (w_ins_rt),
        .i_ins_lat   (w_ins_lat),
        .i_q_addr    (w_q_addr),
        .o_q_busy    (w_busy)
    );

    assign w_s0_haz = (r_s0.use_a && w_busy[0]) || (r_s0.use_b && w_busy[1])
                   || (r_s0.use_c && w_busy[2]);
    assign w_s1_haz = (r_s1.use_a && w_busy[3]) || (r_s1.use_b && w_busy[4])
                   || (r_s1.use_c && w_busy[5]);
    // Slot1 reading slot0's destination cannot co-issue; the scoreboard covers it afterwards.
    assign w_dep    = r_s0.wr && src_match(r_s1, r_s0.rt);

    assign w_iss0 = !rst && !issue_bus.flush && (r_state == PAIR) && !w_s0_haz;
    assign w_iss1 = !rst && !issue_bus.flush
                 && (((r_state == PAIR) && w_iss0 && (r_s0.pipe != r_s1.pipe) && !w_s1_haz
                      && !w_dep)
                     || ((r_state == SLOT1) && !w_s1_haz));
    assign w_ready = !rst && !issue_bus.flush
                  && ((r_state == EMPTY) || ((r_state == PAIR) && w_iss0 && w_iss1)
                      || ((r_state == SLOT1) && w_iss1));
    assign w_accept = issue_bus.pair_valid && w_ready;
    assign issue_bus.pair_ready = w_ready;

    always_comb begin
        w_ins_valid = '0;
        w_ins_rt    = '{default: '0};
        w_ins_lat   = '{default: '0};
        if (w_iss0 && r_s0.wr) begin
            w_ins_valid[r_s0.pipe] = 1'b1;
            w_ins_rt[r_s0.pipe]    = r_s0.rt;
            w_ins_lat[r_s0.pipe]   = r_s0.lat;
        end
        if (w_iss1 && r_s1.wr) begin
            w_ins_valid[r_s1.pipe] = 1'b1;
            w_ins_rt[r_s1.pipe]    = r_s1.rt;
            w_ins_lat[r_s1.pipe]   = r_s1.lat;
        end
    end

    always_comb begin
        issue_bus.iss_ep_valid  = 1'b0;
        issue_bus.iss_ep_opcode = OpNop;
        issue_bus.iss_ep_rt     = '0;
        issue_bus.iss_ep_ra     = '0;
        issue_bus.iss_ep_rb     = '0;
        issue_bus.iss_ep_rc     = '0;
        issue_bus.iss_op_valid  = 1'b0;
        issue_bus.iss_op_opcode = OpNop;
        issue_bus.iss_op_rt     = '0;
        issue_bus.iss_op_ra     = '0;
        issue_bus.iss_op_rb     = '0;
        issue_bus.iss_op_rc     = '0;
        if ((w_iss0 && !r_s0.pipe) || (w_iss1 && !r_s1.pipe)) begin
            issue_bus.iss_ep_valid  = 1'b1;
            issue_bus.iss_ep_opcode = (w_iss0 && !r_s0.pipe) ? r_s0.opcode : r_s1.opcode;
            issue_bus.iss_ep_rt     = (w_iss0 && !r_s0.pipe) ? r_s0.rt : r_s1.rt;
            issue_bus.iss_ep_ra     = (w_iss0 && !r_s0.pipe) ? r_s0.ra : r_s1.ra;
            issue_bus.iss_ep_rb     = (w_iss0 && !r_s0.pipe) ? r_s0.rb : r_s1.rb;
            issue_bus.iss_ep_rc     = (w_iss0 && !r_s0.pipe) ? r_s0.rc : r_s1.rc;
        end
        if ((w_iss0 && r_s0.pipe) || (w_iss1 && r_s1.pipe)) begin
            issue_bus.iss_op_valid  = 1'b1;
            issue_bus.iss_op_opcode = (w_iss0 && r_s0.pipe) ? r_s0.opcode : r_s1.opcode;
            issue_bus.iss_op_rt     = (w_iss0 && r_s0.pipe) ? r_s0.rt : r_s1.rt;
            issue_bus.iss_op_ra     = (w_iss0 && r_s0.pipe) ? r_s0.ra : r_s1.ra;
            issue_bus.iss_op_rb     = (w_iss0 && r_s0.pipe) ? r_s0.rb : r_s1.rb;
            issue_bus.iss_op_rc     = (w_iss0 && r_s0.pipe) ? r_s0.rc : r_s1.rc;
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_s0_d    = r_s0;
        w_s1_d    = r_s1;
        if (issue_bus.flush) begin
            w_state_d = EMPTY;
            w_s0_d    = '0;
            w_s1_d    = '0;
        end else if (w_accept) begin
            w_state_d = PAIR;
            w_s0_d    = w_in0;
            w_s1_d    = w_in1;
        end else begin
            unique case (r_state)
                PAIR: begin
                    if (w_iss0 && w_iss1) begin
                        w_state_d = EMPTY;
                        w_s0_d    = '0;
                        w_s1_d    = '0;
                    end else if (w_iss0) begin
                        w_state_d = SLOT1;
                        w_s0_d    = '0;
                    end
                end
                SLOT1: begin
                    if (w_iss1) begin
                        w_state_d = EMPTY;
                        w_s1_d    = '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= EMPTY;
            r_s0    <= '0;
            r_s1    <= '0;
        end else begin
            r_state <= w_state_d;
            r_s0    <= w_s0_d;
            r_s1    <= w_s1_d;
        end
    end

`ifdef SPU_ISSUE_STATS_EN
    logic        w_raw_stall, w_struct_stall;
    logic [31:0] r_issue_cnt, r_raw_cnt, r_struct_cnt;

    assign w_raw_stall = !rst && !issue_bus.flush
        && (((r_state == PAIR) && !w_iss0)
            || ((r_state == PAIR) && w_iss0 && !w_iss1 && (w_s1_haz || w_dep))
            || ((r_state == SLOT1) && !w_iss1));
    assign w_struct_stall = (r_state == PAIR) && w_iss0 && !w_iss1 && !w_s1_haz && !w_dep;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_issue_cnt  <= '0;
            r_raw_cnt    <= '0;
            r_struct_cnt <= '0;
        end else begin
            r_issue_cnt  <= sat_add(r_issue_cnt, {1'b0, w_iss0} + {1'b0, w_iss1});
            r_raw_cnt    <= sat_add(r_raw_cnt, {1'b0, w_raw_stall});
            r_struct_cnt <= sat_add(r_struct_cnt, {1'b0, w_struct_stall});
        end
    end

    assign stat_issue_cnt        = r_issue_cnt;
    assign stat_raw_stall_cnt    = r_raw_cnt;
    assign stat_struct_stall_cnt = r_struct_cnt;
`endif

endmodule

// File: tb/tb_spu_issue_ctrl.sv
// Directed bench for spu_issue_ctrl: pairing, structural split, RAW stalls, flush and reset.
module tb_spu_issue_ctrl;
    import defines_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    spu_issue_ctrl_if #(.REG_ADDR_WD(7)) u_if ();

`ifdef SPU_ISSUE_STATS_EN
    logic [31:0] st_iss, st_raw, st_str;
`endif

    spu_issue_ctrl #(
        .REG_ADDR_WD (7),
        .MAX_LAT     (7)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
`ifdef SPU_ISSUE_STATS_EN
        .stat_issue_cnt        (st_iss),
        .stat_raw_stall_cnt    (st_raw),
        .stat_struct_stall_cnt (st_str),
`endif
        .issue_bus             (u_if)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_slot(input int s, input logic pipe, input logic [2:0] lat,
                              input logic wr, input logic [6:0] rt, input logic [6:0] ra,
                              input logic [6:0] rb, input logic [6:0] rc,
                              input logic [2:0] uses, input Opcodes op);
        if (s == 0) begin
            u_if.s0_pipe = pipe; u_if.s0_lat = lat; u_if.s0_wr = wr; u_if.s0_rt = rt;
            u_if.s0_ra = ra; u_if.s0_rb = rb; u_if.s0_rc = rc;
            u_if.s0_use_a = uses[2]; u_if.s0_use_b = uses[1]; u_if.s0_use_c = uses[0];
            u_if.s0_opcode = op;
        end else begin
            u_if.s1_pipe = pipe; u_if.s1_lat = lat; u_if.s1_wr = wr; u_if.s1_rt = rt;
            u_if.s1_ra = ra; u_if.s1_rb = rb; u_if.s1_rc = rc;
            u_if.s1_use_a = uses[2]; u_if.s1_use_b = uses[1]; u_if.s1_use_c = uses[0];
            u_if.s1_opcode = op;
        end
    endtask

    task automatic check_valids(input string tag, input logic ep, input logic op,
                                input logic rdy);
        check({tag, "_ep_valid"}, 8'(u_if.iss_ep_valid), 8'(ep));
        check({tag, "_op_valid"}, 8'(u_if.iss_op_valid), 8'(op));
        check({tag, "_ready"},    8'(u_if.pair_ready),   8'(rdy));
    endtask

    initial begin
        rst = 1'b1;
        u_if.flush = 1'b0;
        u_if.pair_valid = 1'b1;
        drive_slot(0, 1'b0, 3'd2, 1'b0, 7'd0, 7'd0, 7'd0, 7'd0, 3'b000, OpNop);
        drive_slot(1, 1'b1, 3'd2, 1'b0, 7'd0, 7'd0, 7'd0, 7'd0, 3'b000, OpNop);
        step();
        check_valids("in_reset", 1'b0, 1'b0, 1'b0);
        step();
        rst = 1'b0;
        u_if.pair_valid = 1'b0;
        #1;
        check_valids("post_reset", 1'b0, 1'b0, 1'b1);

        // Independent even/odd pair issues together
        drive_slot(0, 1'b0, 3'd2, 1'b1, 7'd5, 7'd0, 7'd0, 7'd0, 3'b000, OpAdd);
        drive_slot(1, 1'b1, 3'd2, 1'b0, 7'd0, 7'd9, 7'd0, 7'd0, 3'b100, OpLoad);
        u_if.pair_valid = 1'b1;
        step();
        u_if.pair_valid = 1'b0;
        #1;
        check_valids("dual", 1'b1, 1'b1, 1'b1);
        check("dual_ep_rt", 8'(u_if.iss_ep_rt), 8'd5);
        check("dual_op_ra", 8'(u_if.iss_op_ra), 8'd9);
        check("dual_ep_opc", 8'(u_if.iss_ep_opcode), 8'(OpAdd));
        check("dual_op_opc", 8'(u_if.iss_op_opcode), 8'(OpLoad));
        step();
        check_valids("idle", 1'b0, 1'b0, 1'b1);
        check("idle_ep_rt", 8'(u_if.iss_ep_rt), 8'd0);
        check("idle_op_ra", 8'(u_if.iss_op_ra), 8'd0);

        // Both slots even: split over two cycles
        drive_slot(0, 1'b0, 3'd2, 1'b1, 7'd20, 7'd0, 7'd0, 7'd0, 3'b000, OpSub);
        drive_slot(1, 1'b0, 3'd2, 1'b1, 7'd21, 7'd0, 7'd0, 7'd0, 3'b000, OpShuf);
        u_if.pair_valid = 1'b1;
        step();
        u_if.pair_valid = 1'b0;
        #1;
        check_valids("same_n", 1'b1, 1'b0, 1'b0);
        check("same_n_rt", 8'(u_if.iss_ep_rt), 8'd20);
        step();
        check_valids("same_n1", 1'b1, 1'b0, 1'b1);
        check("same_n1_rt", 8'(u_if.iss_ep_rt), 8'd21);
        check("same_n1_opc", 8'(u_if.iss_ep_opcode), 8'(OpShuf));
        step();

        // Writer rt=10 lat=6, then dependent slot0 waits until N+5
        drive_slot(0, 1'b0, 3'd6, 1'b1, 7'd10, 7'd0, 7'd0, 7'd0, 3'b000, OpLoad);
        drive_slot(1, 1'b1, 3'd2, 1'b0, 7'd0, 7'd0, 7'd0, 7'd0, 3'b000, OpBranch);
        u_if.pair_valid = 1'b1;
        step();
        check_valids("lat_n", 1'b1, 1'b1, 1'b1);
        check("lat_n_rt", 8'(u_if.iss_ep_rt), 8'd10);
        drive_slot(0, 1'b0, 3'd2, 1'b1, 7'd11, 7'd10, 7'd0, 7'd0, 3'b100, OpAdd);
        drive_slot(1, 1'b1, 3'd2, 1'b0, 7'd0, 7'd0, 7'd0, 7'd0, 3'b000, OpStore);
        step();
        u_if.pair_valid = 1'b0;
        #1;
        check_valids("lat_n1", 1'b0, 1'b0, 1'b0);
        for (int i = 2; i <= 4; i++) begin
            step();
            check("lat_stall_ep_valid", 8'(u_if.iss_ep_valid), 8'd0);
        end
        step();
        check_valids("lat_n5", 1'b1, 1'b1, 1'b1);
        check("lat_n5_ra", 8'(u_if.iss_ep_ra), 8'd10);
        step();

        // Register 0 is an ordinary register: intra-pair dep, then lat 3
        drive_slot(0, 1'b0, 3'd3, 1'b1, 7'd0, 7'd0, 7'd0, 7'd0, 3'b000, OpAdd);
        drive_slot(1, 1'b1, 3'd2, 1'b0, 7'd0, 7'd0, 7'd0, 7'd0, 3'b100, OpStore);
        u_if.pair_valid = 1'b1;
        step();
        u_if.pair_valid = 1'b0;
        #1;
        check_valids("r0_n", 1'b1, 1'b0, 1'b0);
        step();
        check_valids("r0_n1", 1'b0, 1'b0, 1'b0);
        step();
        check_valids("r0_n2", 1'b0, 1'b1, 1'b1);
        step();

        // Slot1 rb depends on slot0 rt=3 across pipes
        drive_slot(0, 1'b0, 3'd2, 1'b1, 7'd3, 7'd0, 7'd0, 7'd0, 3'b000, OpAdd);
        drive_slot(1, 1'b1, 3'd2, 1'b0, 7'd0, 7'd0, 7'd3, 7'd0, 3'b010, OpStore);
        u_if.pair_valid = 1'b1;
        step();
        u_if.pair_valid = 1'b0;
        #1;
        check_valids("dep_n", 1'b1, 1'b0, 1'b0);
        step();
        check_valids("dep_n1", 1'b0, 1'b1, 1'b1);
        check("dep_n1_rb", 8'(u_if.iss_op_rb), 8'd3);
        step();

        // Flush in SLOT1 with hazarded slot1; in-flight write survives the flush
        drive_slot(0, 1'b0, 3'd5, 1'b1, 7'd30, 7'd0, 7'd0, 7'd0, 3'b000, OpLoad);
        drive_slot(1, 1'b1, 3'd2, 1'b0, 7'd0, 7'd30, 7'd0, 7'd0, 3'b100, OpStore);
        u_if.pair_valid = 1'b1;
        step();
        u_if.pair_valid = 1'b0;
        #1;
        check_valids("fl_n", 1'b1, 1'b0, 1'b0);
        step();
        check_valids("fl_slot1", 1'b0, 1'b0, 1'b0);
        u_if.flush = 1'b1;
        #1;
        check_valids("fl_assert", 1'b0, 1'b0, 1'b0);
        step();
        u_if.flush = 1'b0;
        #1;
        check_valids("fl_after", 1'b0, 1'b0, 1'b1);
        drive_slot(0, 1'b0, 3'd2, 1'b0, 7'd0, 7'd30, 7'd0, 7'd0, 3'b100, OpAdd);
        drive_slot(1, 1'b1, 3'd2, 1'b0, 7'd0, 7'd0, 7'd0, 7'd0, 3'b000, OpBranch);
        u_if.pair_valid = 1'b1;
        step();
        u_if.pair_valid = 1'b0;
        #1;
        check_valids("fl_sb_hold", 1'b0, 1'b0, 1'b0);
        step();
        check_valids("fl_sb_free", 1'b1, 1'b1, 1'b1);
        step();

        // Reset while stalled in PAIR clears holding regs and scoreboard
        drive_slot(0, 1'b0, 3'd7, 1'b1, 7'd40, 7'd0, 7'd0, 7'd0, 3'b000, OpLoad);
        drive_slot(1, 1'b1, 3'd7, 1'b1, 7'd41, 7'd0, 7'd0, 7'd0, 3'b000, OpShuf);
        u_if.pair_valid = 1'b1;
        step();
        check_valids("rst_wr", 1'b1, 1'b1, 1'b1);
        drive_slot(0, 1'b0, 3'd2, 1'b0, 7'd0, 7'd40, 7'd0, 7'd0, 3'b100, OpAdd);
        drive_slot(1, 1'b1, 3'd2, 1'b0, 7'd0, 7'd0, 7'd41, 7'd0, 3'b010, OpStore);
        step();
        u_if.pair_valid = 1'b0;
        #1;
        check_valids("rst_stall", 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        check_valids("rst_mid", 1'b0, 1'b0, 1'b0);
        step();
        rst = 1'b0;
        #1;
        check_valids("rst_after", 1'b0, 1'b0, 1'b1);
        check("rst_after_rt", 8'(u_if.iss_ep_rt), 8'd0);
        u_if.pair_valid = 1'b1;
        step();
        u_if.pair_valid = 1'b0;
        #1;
        check_valids("rst_fresh", 1'b1, 1'b1, 1'b1);
        check("rst_fresh_ra", 8'(u_if.iss_ep_ra), 8'd40);
        check("rst_fresh_rb", 8'(u_if.iss_op_rb), 8'd41);
        step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
